regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters:
//  req0 = ALU result, req1 = load/multicycle result.

---
 rtl/mips_rf_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 19 +
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// rtl/mips_rf_pkg.sv - shared widths and writeback request type for the register-file writeback arbiter
package mips_rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // r0 is hardwired: writes to it are discarded and it is never pending
    function automatic logic isRegZero(input logic [ADDR_W-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with an external last-grant pointer
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       lg,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // on contention the requester that did not win last time goes first
            2'b11:   gnt = lg ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with busy scoreboard; optional forwarding under REGFILE_WB_FWD_EN
module regfile_wb_arbiter
    import mips_rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_set_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata
`ifdef REGFILE_WB_FWD_EN
    ,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_rs_data,
    output logic [DATA_W-1:0] fwd_rt_data
`endif
);

    wb_req_t           req0;
    wb_req_t           req1;
    logic              lastGrant;
    logic [1:0]        arbGnt;
    logic [1:0]        gnt;
    logic              wbFire;
    logic [ADDR_W-1:0] wbRd;
    logic [DATA_W-1:0] wbData;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busyNext;
    logic              rsPending;
    logic              rtPending;

    assign req0 = '{valid: req0_valid, rd: req0_rd, data: req0_data};
    assign req1 = '{valid: req1_valid, rd: req1_rd, data: req1_data};

    rr_arbiter2 u_arb (
        .req (({req1.valid, req0.valid})),
        .lg  (lastGrant),
        .gnt (arbGnt)
    );

    assign gnt        = reset ? 2'b00 : arbGnt;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign wbFire = |gnt;
    assign wbRd   = gnt[1] ? req1.rd   : req0.rd;
    assign wbData = gnt[1] ? req1.data : req0.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we     <= 1'b0;
            rf_rd     <= REG_ZERO;
            rf_wdata  <= '0;
            lastGrant <= 1'b1;
        end else begin
            rf_we <= wbFire && !isRegZero(wbRd);
            if (wbFire) begin
                rf_rd    <= wbRd;
                rf_wdata <= wbData;
            end
            // pointer only advances when both sides actually competed
            if (req0.valid && req1.valid) begin
                lastGrant <= gnt[1];
            end
        end
    end

    // clear on the transferring grant first so a same-cycle set on that index wins
    always_comb begin
        busyNext = busy;
        if (wbFire) begin
            busyNext[wbRd] = 1'b0;
        end
        if (sb_set && !isRegZero(sb_set_rd)) begin
            busyNext[sb_set_rd] = 1'b1;
        end
        busyNext[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    assign rsPending = busy[rs] && !isRegZero(rs);
    assign rtPending = busy[rt] && !isRegZero(rt);

`ifdef REGFILE_WB_FWD_EN
    assign fwd_rs_hit  = rf_we && (rf_rd == rs) && !isRegZero(rs);
    assign fwd_rt_hit  = rf_we && (rf_rd == rt) && !isRegZero(rt);
    assign fwd_rs_data = rf_wdata;
    assign fwd_rt_data = rf_wdata;
    assign rs_busy     = rsPending && !fwd_rs_hit;
    assign rt_busy     = rtPending && !fwd_rt_hit;
`else
    assign rs_busy = rsPending;
    assign rt_busy = rtPending;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - table-driven scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import mips_rf_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_rd, req1_rd;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_set_rd, rs, rt;
    logic              rs_busy, rt_busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
`ifdef REGFILE_WB_FWD_EN
    logic              fwd_rs_hit, fwd_rt_hit;
    logic [DATA_W-1:0] fwd_rs_data, fwd_rt_data;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sb_set     (sb_set),
        .sb_set_rd  (sb_set_rd),
        .rs         (rs),
        .rt         (rt),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata)
`ifdef REGFILE_WB_FWD_EN
        ,
        .fwd_rs_hit  (fwd_rs_hit),
        .fwd_rt_hit  (fwd_rt_hit),
        .fwd_rs_data (fwd_rs_data),
        .fwd_rt_data (fwd_rt_data)
`endif
    );

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        set;
        logic [4:0]  setRd;
        logic [4:0]  rsIdx;
        logic [4:0]  rtIdx;
        logic        g0;
        logic        g1;
        logic        rsB;
        logic        rtB;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t  expQ[$];
    vec_t vecs[14];
    int   nVec = 0;
    int   nErr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyVec(input vec_t v, input string tag);
        wr_t  cur;
        wr_t  nxt;
        logic hitRs;
        logic hitRt;
        reset      = v.rst;
        req0_valid = v.v0;  req0_rd = v.rd0;  req0_data = v.d0;
        req1_valid = v.v1;  req1_rd = v.rd1;  req1_data = v.d1;
        sb_set     = v.set; sb_set_rd = v.setRd;
        rs         = v.rsIdx; rt = v.rtIdx;
        @(negedge clk);
        if (expQ.size() == 0) begin
            nVec++; nErr++;
            $display("FAIL %s queue: got empty expected an entry", tag);
            cur = '{1'b0, 5'd0, 32'd0};
        end else begin
            cur = expQ.pop_front();
        end
        check({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, cur.we});
        if (cur.we) begin
            check({tag, " rf_rd"}, {27'd0, rf_rd}, {27'd0, cur.rd});
            check({tag, " rf_wdata"}, rf_wdata, cur.data);
        end
        check({tag, " req0_ready"}, {31'd0, req0_ready}, {31'd0, v.g0});
        check({tag, " req1_ready"}, {31'd0, req1_ready}, {31'd0, v.g1});
        hitRs = cur.we && (cur.rd == v.rsIdx) && (v.rsIdx != 5'd0);
        hitRt = cur.we && (cur.rd == v.rtIdx) && (v.rtIdx != 5'd0);
`ifdef REGFILE_WB_FWD_EN
        check({tag, " fwd_rs_hit"}, {31'd0, fwd_rs_hit}, {31'd0, hitRs});
        check({tag, " fwd_rt_hit"}, {31'd0, fwd_rt_hit}, {31'd0, hitRt});
        if (hitRs) check({tag, " fwd_rs_data"}, fwd_rs_data, cur.data);
        if (hitRt) check({tag, " fwd_rt_data"}, fwd_rt_data, cur.data);
        check({tag, " rs_busy"}, {31'd0, rs_busy}, {31'd0, v.rsB && !hitRs});
        check({tag, " rt_busy"}, {31'd0, rt_busy}, {31'd0, v.rtB && !hitRt});
`else
        check({tag, " rs_busy"}, {31'd0, rs_busy}, {31'd0, v.rsB});
        check({tag, " rt_busy"}, {31'd0, rt_busy}, {31'd0, v.rtB});
`endif
        if (v.rst)     nxt = '{1'b0, 5'd0, 32'd0};
        else if (v.g0) nxt = '{v.rd0 != 5'd0, v.rd0, v.d0};
        else if (v.g1) nxt = '{v.rd1 != 5'd0, v.rd1, v.d1};
        else           nxt = '{1'b0, 5'd0, 32'd0};
        expQ.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         rst   v0    rd0   d0            v1    rd1   d1          set   setRd rs    rt    g0    g1    rsB   rtB
        vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 5'd3, 32'h33,       1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 5'd6, 32'h66,       1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,   1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h78,   1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 5'd7, 32'h79,       1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        sb_set = 1'b0; sb_set_rd = '0; rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rf_we", {31'd0, rf_we}, 32'd0);
        check("reset rf_rd", {27'd0, rf_rd}, 32'd0);
        check("reset rf_wdata", rf_wdata, 32'd0);
        @(posedge clk);
        #1;
        expQ.push_back('{1'b0, 5'd0, 32'd0});

        // requests during reset must not be granted
        applyVec('{1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, "rstreq");

        for (int i = 0; i < 14; i++) begin
            applyVec(vecs[i], $sformatf("v%0d", i));
        end

        // contention moves lg to 0, then reset mid-grant must drop the write, clear busy and restore lg
        applyVec('{1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}, "r1");
        applyVec('{1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}, "r2");
        applyVec('{1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}, "r3");
        applyVec('{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}, "r4");

        // write to rd 9 in the same cycle a new producer re-marks it
        applyVec('{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0}, "f1");
        applyVec('{1'b0, 1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1}, "f2");
        applyVec('{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1}, "f3");
        applyVec('{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}, "f4");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
